// File: rtl/ex_mem_latch_pkg.sv
// Shared MEM-stage constants: store/load width encodings and default bus sizes.
// The EX/MEM latch and its pipeline-register primitive import this package.
package ex_mem_latch_pkg;

  localparam int unsigned DefaultBusSize     = 32;
  localparam int unsigned DefaultRegAddrSize = 5;

  // Store width select (i_mem_wr_src)
  localparam logic [1:0] MemWrWord = 2'd0;
  localparam logic [1:0] MemWrHalf = 2'd1;
  localparam logic [1:0] MemWrByte = 2'd2;

  // Load select (i_mem_rd_src)
  localparam logic [2:0] MemRdWord     = 3'd0;
  localparam logic [2:0] MemRdSextHalf = 3'd1;
  localparam logic [2:0] MemRdSextByte = 3'd2;
  localparam logic [2:0] MemRdUextHalf = 3'd3;
  localparam logic [2:0] MemRdUextByte = 3'd4;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } latch_state_e;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset, advance enable and
// bubble load (an enabled edge with bubble set loads all zeros).
module pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_bubble,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] q_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_q <= '0;
    end else if (i_enable) begin
      q_q <= i_bubble ? '0 : i_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: captures ALU result, store data, destination and
// MEM/WB control; supports stepping, flush-to-bubble and sticky HALT retirement.
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int unsigned BUS_SIZE      = DefaultBusSize,
  parameter int unsigned REG_ADDR_SIZE = DefaultRegAddrSize
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic                     i_halt,
  input  logic                     i_mem_wr_rd,
  input  logic [1:0]               i_mem_wr_src,
  input  logic [2:0]               i_mem_rd_src,
  input  logic                     i_reg_wr,
  input  logic                     i_mem_to_reg,
  input  logic [BUS_SIZE-1:0]      i_alu_res,
  input  logic [BUS_SIZE-1:0]      i_bus_b,
  input  logic [REG_ADDR_SIZE-1:0] i_rd_addr,
  output logic                     o_mem_wr_rd,
  output logic [1:0]               o_mem_wr_src,
  output logic [2:0]               o_mem_rd_src,
  output logic                     o_reg_wr,
  output logic                     o_mem_to_reg,
  output logic [BUS_SIZE-1:0]      o_alu_res,
  output logic [BUS_SIZE-1:0]      o_bus_b,
  output logic [REG_ADDR_SIZE-1:0] o_rd_addr,
  output logic                     o_valid,
  output logic                     o_halt
);

  localparam int unsigned FieldWidth = 8 + 2 * BUS_SIZE + REG_ADDR_SIZE;

  latch_state_e     state_q;
  logic             valid_q;
  logic             halt_q;
  logic             advance;
  logic             bubble;
  logic [FieldWidth-1:0] fields_d;
  logic [FieldWidth-1:0] fields_q;

  // HALTED forces an advancing bubble every edge regardless of enable/flush.
  always_comb begin
    advance = i_enable;
    bubble  = i_flush | i_halt;
    if (state_q == StHalted) begin
      advance = 1'b1;
      bubble  = 1'b1;
    end
  end

  assign fields_d = {i_mem_wr_rd, i_mem_wr_src, i_mem_rd_src, i_reg_wr, i_mem_to_reg,
                     i_alu_res, i_bus_b, i_rd_addr};

  pipe_reg #(
    .Width(FieldWidth)
  ) u_fields (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_enable(advance),
    .i_bubble(bubble),
    .i_d     (fields_d),
    .o_q     (fields_q)
  );

  assign {o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src, o_reg_wr, o_mem_to_reg,
          o_alu_res, o_bus_b, o_rd_addr} = fields_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (i_enable) begin
            valid_q <= ~(i_flush | i_halt);
            // A flushed HALT is squashed and never retires.
            if (!i_flush && i_halt) begin
              state_q <= StHalted;
              halt_q  <= 1'b1;
            end
          end
        end
        StHalted: begin
          valid_q <= 1'b0;
          halt_q  <= 1'b1;
        end
        default: begin
          state_q <= StRun;
          valid_q <= 1'b0;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_halt  = halt_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed self-checking bench for ex_mem_latch: reset, capture, stall, flush,
// HALT retirement, reset priority and illegal-encoding pass-through.
module tb_ex_mem_latch;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        flush;
  logic        halt;
  logic        mem_wr_rd;
  logic [1:0]  mem_wr_src;
  logic [2:0]  mem_rd_src;
  logic        reg_wr;
  logic        mem_to_reg;
  logic [31:0] alu_res;
  logic [31:0] bus_b;
  logic [4:0]  rd_addr;
  logic        q_mem_wr_rd;
  logic [1:0]  q_mem_wr_src;
  logic [2:0]  q_mem_rd_src;
  logic        q_reg_wr;
  logic        q_mem_to_reg;
  logic [31:0] q_alu_res;
  logic [31:0] q_bus_b;
  logic [4:0]  q_rd_addr;
  logic        q_valid;
  logic        q_halt;

  int n_vec = 0;
  int n_err = 0;

  ex_mem_latch #(
    .BUS_SIZE     (32),
    .REG_ADDR_SIZE(5)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_flush     (flush),
    .i_halt      (halt),
    .i_mem_wr_rd (mem_wr_rd),
    .i_mem_wr_src(mem_wr_src),
    .i_mem_rd_src(mem_rd_src),
    .i_reg_wr    (reg_wr),
    .i_mem_to_reg(mem_to_reg),
    .i_alu_res   (alu_res),
    .i_bus_b     (bus_b),
    .i_rd_addr   (rd_addr),
    .o_mem_wr_rd (q_mem_wr_rd),
    .o_mem_wr_src(q_mem_wr_src),
    .o_mem_rd_src(q_mem_rd_src),
    .o_reg_wr    (q_reg_wr),
    .o_mem_to_reg(q_mem_to_reg),
    .o_alu_res   (q_alu_res),
    .o_bus_b     (q_bus_b),
    .o_rd_addr   (q_rd_addr),
    .o_valid     (q_valid),
    .o_halt      (q_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".mem_wr_rd"}, 32'(q_mem_wr_rd), 32'd0);
    check({tag, ".mem_wr_src"}, 32'(q_mem_wr_src), 32'd0);
    check({tag, ".mem_rd_src"}, 32'(q_mem_rd_src), 32'd0);
    check({tag, ".reg_wr"}, 32'(q_reg_wr), 32'd0);
    check({tag, ".mem_to_reg"}, 32'(q_mem_to_reg), 32'd0);
    check({tag, ".alu_res"}, q_alu_res, 32'd0);
    check({tag, ".bus_b"}, q_bus_b, 32'd0);
    check({tag, ".rd_addr"}, 32'(q_rd_addr), 32'd0);
    check({tag, ".valid"}, 32'(q_valid), 32'd0);
    check({tag, ".halt"}, 32'(q_halt), 32'd0);
  endtask

  task automatic set_inputs(input logic wr_rd, input logic [1:0] wr_src, input logic [2:0] rd_src,
                            input logic rwr, input logic m2r, input logic [31:0] alu,
                            input logic [31:0] bb, input logic [4:0] rd);
    mem_wr_rd  = wr_rd;
    mem_wr_src = wr_src;
    mem_rd_src = rd_src;
    reg_wr     = rwr;
    mem_to_reg = m2r;
    alu_res    = alu;
    bus_b      = bb;
    rd_addr    = rd;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    flush  = 1'b0;
    halt   = 1'b0;
    set_inputs(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    step();

    // Reset: preload random values, then pulse reset for one cycle.
    reset  = 1'b0;
    enable = 1'b1;
    set_inputs(1'b1, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 4)), 1'b1, 1'b1,
               $urandom | 32'h1, $urandom, 5'($urandom_range(1, 31)));
    step();
    check("preload.valid", 32'(q_valid), 32'd1);
    reset = 1'b1;
    step();
    check_zero("reset");
    reset = 1'b0;

    // Capture.
    enable = 1'b1;
    set_inputs(1'b0, 2'd0, 3'd2, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd7);
    step();
    check("cap.alu_res", q_alu_res, 32'h0000_0010);
    check("cap.bus_b", q_bus_b, 32'hDEAD_BEEF);
    check("cap.rd_addr", 32'(q_rd_addr), 32'd7);
    check("cap.reg_wr", 32'(q_reg_wr), 32'd1);
    check("cap.mem_rd_src", 32'(q_mem_rd_src), 32'd2);
    check("cap.mem_wr_rd", 32'(q_mem_wr_rd), 32'd0);
    check("cap.valid", 32'(q_valid), 32'd1);
    check("cap.halt", 32'(q_halt), 32'd0);

    // Stall: inputs change, outputs hold.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b1, 2'd1, 3'd4, 1'b0, 1'b1, 32'h1000 + 32'(i), 32'h5555_0000 + 32'(i),
                 5'(20 + i));
      flush = i[0];
      halt  = (i == 2);
      step();
      check("stall.alu_res", q_alu_res, 32'h0000_0010);
      check("stall.bus_b", q_bus_b, 32'hDEAD_BEEF);
      check("stall.rd_addr", 32'(q_rd_addr), 32'd7);
      check("stall.valid", 32'(q_valid), 32'd1);
      check("stall.halt", 32'(q_halt), 32'd0);
    end

    // Flush with a store and a HALT in EX: bubble, HALT not retired.
    enable = 1'b1;
    flush  = 1'b1;
    halt   = 1'b1;
    set_inputs(1'b1, 2'd2, 3'd1, 1'b1, 1'b1, 32'hCAFE_0000, 32'h1234_5678, 5'd9);
    step();
    check_zero("flush");

    // Still in RUN: a store is captured normally.
    flush = 1'b0;
    halt  = 1'b0;
    set_inputs(1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_ABCD, 5'd0);
    step();
    check("store.mem_wr_rd", 32'(q_mem_wr_rd), 32'd1);
    check("store.mem_wr_src", 32'(q_mem_wr_src), 32'd1);
    check("store.alu_res", q_alu_res, 32'h0000_1234);
    check("store.valid", 32'(q_valid), 32'd1);

    // Halt retirement.
    halt = 1'b1;
    set_inputs(1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0, 5'd3);
    step();
    check("halt.halt", 32'(q_halt), 32'd1);
    check("halt.valid", 32'(q_valid), 32'd0);
    check("halt.reg_wr", 32'(q_reg_wr), 32'd0);
    check("halt.alu_res", q_alu_res, 32'd0);

    // HALTED: further captures, stalls and flushes all produce bubbles.
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable = (i != 1);
      flush  = (i == 2);
      set_inputs(1'b1, 2'd2, 3'd3, 1'b1, 1'b1, 32'h7000_0000 + 32'(i), 32'h1, 5'(i + 1));
      step();
      check("halted.reg_wr", 32'(q_reg_wr), 32'd0);
      check("halted.mem_wr_rd", 32'(q_mem_wr_rd), 32'd0);
      check("halted.alu_res", q_alu_res, 32'd0);
      check("halted.valid", 32'(q_valid), 32'd0);
      check("halted.halt", 32'(q_halt), 32'd1);
    end

    // Reset out of HALTED.
    reset = 1'b1;
    step();
    check_zero("halt_reset");
    reset  = 1'b0;
    enable = 1'b1;
    flush  = 1'b0;
    set_inputs(1'b0, 2'd0, 3'd4, 1'b1, 1'b1, 32'h0000_0042, 32'h0000_0043, 5'd31);
    step();
    check("post_reset.alu_res", q_alu_res, 32'h0000_0042);
    check("post_reset.rd_addr", 32'(q_rd_addr), 32'd31);
    check("post_reset.valid", 32'(q_valid), 32'd1);
    check("post_reset.halt", 32'(q_halt), 32'd0);

    // Reset wins over enable + HALT on the same edge.
    reset = 1'b1;
    halt  = 1'b1;
    step();
    check_zero("simul");
    reset  = 1'b0;
    halt   = 1'b0;
    enable = 1'b0;
    step();
    check("simul_after.halt", 32'(q_halt), 32'd0);
    check("simul_after.valid", 32'(q_valid), 32'd0);

    // Illegal encodings pass through unchanged.
    enable = 1'b1;
    set_inputs(1'b1, 2'd3, 3'd7, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 5'd16);
    step();
    check("illegal.mem_wr_src", 32'(q_mem_wr_src), 32'd3);
    check("illegal.mem_rd_src", 32'(q_mem_rd_src), 32'd7);
    check("illegal.alu_res", q_alu_res, 32'hFFFF_FFFF);
    check("illegal.bus_b", q_bus_b, 32'h8000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

Pipeline register between the EX stage and the MEM stage of the MIPS core. It captures the ALU result, the store operand (bus B), the destination register and the MEM/WB control fields at the end of EX. It presents them, registered, to the MEM stage and to the forwarding unit. It also supports debug stepping (enable), hazard flushing (bubble insertion) and HALT retirement. Once a HALT has been captured, the stage freezes into a permanent bubble until reset.

## Interface
Parameters:
- BUS_SIZE, 32, data width of ALU result and bus B
- REG_ADDR_SIZE, 5, register-file address width

Ports:
- i_clk  in  1  single clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  advance pipeline this cycle (debug-unit step / run)
- i_flush  in  1  load a bubble instead of the inputs
- i_halt  in  1  instruction in EX is HALT
- i_mem_wr_rd  in  1  1 = store, 0 = load/no write
- i_mem_wr_src  in  2  store width select: 0 word, 1 halfword, 2 byte
- i_mem_rd_src  in  3  load select: 0 word, 1 sext half, 2 sext byte, 3 uext half, 4 uext byte
- i_reg_wr  in  1  instruction writes register file
- i_mem_to_reg  in  1  WB source: 1 memory data, 0 ALU result
- i_alu_res  in  BUS_SIZE  ALU result / memory address
- i_bus_b  in  BUS_SIZE  store data
- i_rd_addr  in  REG_ADDR_SIZE  destination register
- o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src, o_reg_wr, o_mem_to_reg, o_alu_res, o_bus_b, o_rd_addr  out  (same widths)  registered copies
- o_valid  out  1  register holds a real instruction (not a bubble)
- o_halt  out  1  HALT has reached MEM; sticky

## Operation
- Two states: RUN, HALTED. Reset → RUN.
- Bubble value: every control output 0, data outputs 0, o_valid 0, o_rd_addr 0.
- RUN:
  - i_enable = 0: hold all outputs unchanged.
  - i_enable = 1, i_flush = 1: load bubble. i_halt is ignored; a flushed HALT is not retired.
  - i_enable = 1, i_flush = 0, i_halt = 0: capture all inputs; o_valid ← 1.
  - i_enable = 1, i_flush = 0, i_halt = 1: load bubble with o_halt ← 1, go to HALTED.
- HALTED:
  - Every edge loads the bubble, regardless of i_enable or i_flush.
  - o_halt stays 1.
  - Leave only via i_reset.
- i_mem_wr_src values 3 and i_mem_rd_src values 5–7 are illegal. They are passed through unchanged; the decoder never produces them.
- Priority: i_reset > HALTED > ~i_enable > i_flush > i_halt > capture.

## Timing
- Reset value: all outputs 0, state RUN, taking effect the cycle after reset is sampled high.
- Latency: 1 cycle from input sample to output.
- Outputs are driven only from flops; there is no combinational path from input to output.
- A store is visible to the data memory in the cycle after capture, and only for that instruction. A hold keeps o_mem_wr_rd asserted, and memory rewrites the same address with the same data, which is harmless.
- o_halt rises in the cycle after the HALT capture edge.
- Reset asserted mid-hold or in HALTED: outputs go to 0 on the next edge, no exceptions.

## Structure
- Shared MEM package/header (with the existing memory constants):
  - mem_wr_src encodings: WORD = 0, HALF = 1, BYTE = 2
  - mem_rd_src encodings: WORD = 0, SEXT_HALF = 1, SEXT_BYTE = 2, UEXT_HALF = 3, UEXT_BYTE = 4
  - default BUS_SIZE and REG_ADDR_SIZE
- One generic sub-module, `pipe_reg`: parameterised width, with reset, enable and load-bubble inputs. All fields are instantiated through it or packed into one vector for it.
- The RUN/HALTED state and the valid flag live in the top module.

## Test plan
- Reset: preload random values, pulse i_reset for 1 cycle → every output 0 on the next edge, o_halt 0.
- Capture:
  - Stimulus: i_enable 1; i_alu_res 0x0000_0010; i_bus_b 0xDEAD_BEEF; i_rd_addr 7; i_reg_wr 1; i_mem_rd_src 2.
  - Response: identical values one cycle later, o_valid 1.
- Stall: i_enable 0 for 3 cycles while inputs change → outputs keep 0x0000_0010 / 0xDEAD_BEEF / 7 throughout.
- Flush:
  - Stimulus: i_enable 1, i_flush 1 with i_mem_wr_rd 1, i_halt 1.
  - Response: o_mem_wr_rd 0, o_valid 0, o_halt 0, state stays RUN.
- Halt:
  - Stimulus: i_halt 1, i_enable 1.
  - Response: next cycle o_halt 1 and o_valid 0. Subsequent captures with i_enable 1 and i_reg_wr 1 keep o_reg_wr 0 and o_halt 1; i_reset then returns everything to 0.
- Simultaneous: i_reset 1 together with i_enable 1 and i_halt 1 → outputs 0, o_halt 0.
